// File: rtl/m_counter_updn.sv
// -----------------------------------------------------------------------------
// m_counter_updn
//   Synchronous up/down counter with an enable-gated prescaler, parallel load
//   (clamped to the modulus), programmable modulus and wrap/saturate end mode.
//   The TC output lets counters be cascaded: TC of one stage feeds EN of the
//   next stage.
//
// Parameters
//   width of the count register (WIDTH): 1..32
//   count modulus (MOD): 2..2^WIDTH; Q spans 0..MOD-1
//   enabled clocks per count step (PRESCALE): 1..65535
//
// Ports
//   CLK  in   clock, rising edge
//   RST  in   synchronous reset, active-low
//   EN   in   count enable, gates the prescaler and the count
//   UP   in   1 = increment, 0 = decrement
//   SAT  in   1 = saturate at the range ends, 0 = wrap
//   LD   in   synchronous parallel load of min(D, MOD-1)
//   D    in   load value
//   Q    out  registered count
//   TC   out  terminal count (combinational): STEP at the end of the range
//   OVF  out  registered one-cycle pulse after a wrap step
//   STEP out  prescaler tick (combinational): EN and prescaler at PRESCALE-1
// -----------------------------------------------------------------------------
module m_counter_updn #(
   parameter int     WIDTH    = 8,
   parameter longint MOD      = 256,
   parameter int     PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             UP,
   input  logic             SAT,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             OVF,
   output logic             STEP
);

   // Top count value. For MOD = 2^WIDTH this is all-ones with no extra bit.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
   localparam logic [15:0]      PMAX = 16'(PRESCALE - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [15:0]      pre_q, pre_d;
   logic             ovf_q, ovf_d;
   logic             at_end;

   // Load values above the top of the range are clamped to MOD-1.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   // Count is at the end of the range for the current direction.
   assign at_end = UP ? (cnt_q == MAXV) : (cnt_q == '0);

   assign STEP = EN && (pre_q == PMAX);
   assign TC   = STEP && at_end;
   assign Q    = cnt_q;
   assign OVF  = ovf_q;

   always_comb begin
      cnt_d = cnt_q;
      pre_d = pre_q;
      ovf_d = 1'b0;
      if (LD) begin
         // Load wins over a coincident step and discards prescaler progress.
         cnt_d = clamp_load(D);
         pre_d = '0;
      end else if (EN) begin
         pre_d = STEP ? 16'd0 : pre_q + 16'd1;
         if (STEP) begin
            if (at_end) begin
               // Saturate mode holds the count; wrap mode jumps to the
               // opposite end of the range and flags it.
               if (!SAT) begin
                  cnt_d = UP ? '0 : MAXV;
                  ovf_d = 1'b1;
               end
            end else begin
               cnt_d = UP ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_q <= '0;
         pre_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_m_counter_updn.sv
// -----------------------------------------------------------------------------
// tb_m_counter_updn
//   Five counters share one set of stimulus inputs:
//     0: WIDTH=8 MOD=256 PRESCALE=1
//     1: WIDTH=8 MOD=10  PRESCALE=1
//     2: WIDTH=8 MOD=10  PRESCALE=4
//     3: WIDTH=4 MOD=10  PRESCALE=1  (cascade stage 0)
//     4: WIDTH=4 MOD=10  PRESCALE=1  (cascade stage 1, EN = TC of stage 0)
//   Every cycle all five are compared against an arithmetic reference model;
//   a vector table and hand-written sequences add explicit expectations.
// -----------------------------------------------------------------------------
module tb_m_counter_updn;

   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0, ld = 1'b0;
   logic [7:0] d = 8'd0;

   logic [7:0] q_a, q_b, q_c;
   logic [3:0] q_k0, q_k1;
   logic       tc_a, tc_b, tc_c, tc_k0, tc_k1;
   logic       ovf_a, ovf_b, ovf_c, ovf_k0, ovf_k1;
   logic       st_a, st_b, st_c, st_k0, st_k1;

   always #5 clk = ~clk;

   m_counter_updn #(.WIDTH(8), .MOD(256), .PRESCALE(1)) u_a (
      .CLK(clk), .RST(rst), .EN(en), .UP(up), .SAT(sat), .LD(ld), .D(d),
      .Q(q_a), .TC(tc_a), .OVF(ovf_a), .STEP(st_a));
   m_counter_updn #(.WIDTH(8), .MOD(10), .PRESCALE(1)) u_b (
      .CLK(clk), .RST(rst), .EN(en), .UP(up), .SAT(sat), .LD(ld), .D(d),
      .Q(q_b), .TC(tc_b), .OVF(ovf_b), .STEP(st_b));
   m_counter_updn #(.WIDTH(8), .MOD(10), .PRESCALE(4)) u_c (
      .CLK(clk), .RST(rst), .EN(en), .UP(up), .SAT(sat), .LD(ld), .D(d),
      .Q(q_c), .TC(tc_c), .OVF(ovf_c), .STEP(st_c));
   m_counter_updn #(.WIDTH(4), .MOD(10), .PRESCALE(1)) u_k0 (
      .CLK(clk), .RST(rst), .EN(en), .UP(up), .SAT(sat), .LD(ld), .D(d[3:0]),
      .Q(q_k0), .TC(tc_k0), .OVF(ovf_k0), .STEP(st_k0));
   m_counter_updn #(.WIDTH(4), .MOD(10), .PRESCALE(1)) u_k1 (
      .CLK(clk), .RST(rst), .EN(tc_k0), .UP(up), .SAT(sat), .LD(ld), .D(d[3:0]),
      .Q(q_k1), .TC(tc_k1), .OVF(ovf_k1), .STEP(st_k1));

   logic [7:0] dq [5];
   logic       dtc [5], dovf [5], dstep [5];
   assign dq[0] = q_a;  assign dq[1] = q_b;  assign dq[2] = q_c;
   assign dq[3] = {4'b0, q_k0};  assign dq[4] = {4'b0, q_k1};
   assign dtc[0] = tc_a;  assign dtc[1] = tc_b;  assign dtc[2] = tc_c;
   assign dtc[3] = tc_k0; assign dtc[4] = tc_k1;
   assign dovf[0] = ovf_a;  assign dovf[1] = ovf_b;  assign dovf[2] = ovf_c;
   assign dovf[3] = ovf_k0; assign dovf[4] = ovf_k1;
   assign dstep[0] = st_a;  assign dstep[1] = st_b;  assign dstep[2] = st_c;
   assign dstep[3] = st_k0; assign dstep[4] = st_k1;

   // Reference model state
   int mod_c [5] = '{256, 10, 10, 10, 10};
   int ps_c  [5] = '{1, 1, 4, 1, 1};
   int m_q   [5] = '{0, 0, 0, 0, 0};
   int m_pre [5] = '{0, 0, 0, 0, 0};
   bit m_ovf [5] = '{0, 0, 0, 0, 0};
   bit m_step[5], m_tc[5];
   logic s_step[5], s_tc[5];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check combinational outputs before the edge,
   // advance the model, check registered outputs after the edge.
   task automatic tick(input logic r, input logic e, input logic u,
                       input logic s, input logic l, input logic [7:0] dv);
      int en_i, dval, nq;
      rst = r; en = e; up = u; sat = s; ld = l; d = dv;
      #2;
      for (int i = 0; i < 5; i++) begin
         en_i      = (i == 4) ? int'(m_tc[3]) : int'(e);
         m_step[i] = (en_i != 0) && (m_pre[i] == ps_c[i] - 1);
         m_tc[i]   = m_step[i] && (u ? (m_q[i] == mod_c[i] - 1) : (m_q[i] == 0));
         s_step[i] = dstep[i];
         s_tc[i]   = dtc[i];
         chk($sformatf("step%0d", i), longint'(dstep[i]), longint'(m_step[i]));
         chk($sformatf("tc%0d", i), longint'(dtc[i]), longint'(m_tc[i]));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         en_i = (i == 4) ? int'(m_tc[3]) : int'(e);
         dval = (i >= 3) ? int'(dv[3:0]) : int'(dv);
         m_ovf[i] = 1'b0;
         if (!r) begin
            m_q[i] = 0; m_pre[i] = 0;
         end else if (l) begin
            m_q[i] = (dval < mod_c[i] - 1) ? dval : mod_c[i] - 1;
            m_pre[i] = 0;
         end else if (en_i != 0) begin
            if (m_step[i]) begin
               m_pre[i] = 0;
               nq = u ? m_q[i] + 1 : m_q[i] - 1;
               if (nq == mod_c[i] || nq < 0) begin
                  if (!s) begin
                     m_q[i] = (nq + mod_c[i]) % mod_c[i];
                     m_ovf[i] = 1'b1;
                  end
               end else begin
                  m_q[i] = nq;
               end
            end else begin
               m_pre[i] = m_pre[i] + 1;
            end
         end
         chk($sformatf("q%0d", i), longint'(dq[i]), longint'(m_q[i]));
         chk($sformatf("ovf%0d", i), longint'(dovf[i]), longint'(m_ovf[i]));
      end
   endtask

   typedef struct {
      logic r, e, u, s, l;
      logic [7:0] dv;
      logic xstep, xtc;
      int   xq;
      logic xovf;
   } vec_t;

   vec_t vt [20];

   initial begin
      int n, v, ovf_cnt;

      // Vectors for counter 1 (MOD=10, PRESCALE=1):
      //           r  e  u  s  l  d    step tc  q  ovf
      vt[0]  = '{0, 0, 0, 0, 0, 0,   0, 0,  0, 0};  // reset
      vt[1]  = '{1, 0, 0, 0, 1, 0,   0, 0,  0, 0};  // load 0
      vt[2]  = '{1, 1, 0, 0, 0, 0,   1, 1,  9, 1};  // down wrap 0 -> 9
      vt[3]  = '{1, 1, 0, 0, 0, 0,   1, 0,  8, 0};  // 9 -> 8
      vt[4]  = '{1, 1, 1, 0, 1, 200, 1, 0,  9, 0};  // load clamp over a step
      vt[5]  = '{1, 0, 1, 0, 1, 8,   0, 0,  8, 0};  // load 8
      vt[6]  = '{1, 1, 1, 1, 0, 0,   1, 0,  9, 0};  // saturate up: 8 -> 9
      vt[7]  = '{1, 1, 1, 1, 0, 0,   1, 1,  9, 0};  // hold at 9
      vt[8]  = '{1, 1, 1, 1, 0, 0,   1, 1,  9, 0};  // hold at 9
      vt[9]  = '{1, 1, 0, 1, 0, 0,   1, 0,  8, 0};  // reverse: 9 -> 8
      vt[10] = '{1, 1, 1, 0, 0, 0,   1, 0,  9, 0};  // 8 -> 9
      vt[11] = '{1, 1, 1, 0, 1, 200, 1, 1,  9, 0};  // load beats wrap step
      vt[12] = '{0, 1, 1, 0, 1, 5,   1, 1,  0, 0};  // reset beats load
      vt[13] = '{1, 1, 1, 0, 0, 0,   1, 0,  1, 0};  // 0 -> 1
      vt[14] = '{1, 0, 1, 0, 0, 0,   0, 0,  1, 0};  // EN=0 holds
      vt[15] = '{1, 0, 1, 0, 1, 9,   0, 0,  9, 0};  // load 9
      vt[16] = '{1, 1, 1, 0, 0, 0,   1, 1,  0, 1};  // up wrap 9 -> 0
      vt[17] = '{1, 1, 1, 0, 0, 0,   1, 0,  1, 0};  // ovf clears
      vt[18] = '{1, 1, 0, 1, 1, 0,   1, 0,  0, 0};  // load 0
      vt[19] = '{1, 1, 0, 1, 0, 0,   1, 1,  0, 0};  // saturate down holds

      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         tick(vt[i].r, vt[i].e, vt[i].u, vt[i].s, vt[i].l, vt[i].dv);
         chk($sformatf("vec%0d_step", i), longint'(s_step[1]), longint'(vt[i].xstep));
         chk($sformatf("vec%0d_tc", i), longint'(s_tc[1]), longint'(vt[i].xtc));
         chk($sformatf("vec%0d_q", i), longint'(q_b), longint'(vt[i].xq));
         chk($sformatf("vec%0d_ovf", i), longint'(ovf_b), longint'(vt[i].xovf));
      end

      // Up-wrap through the full 8-bit range
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk("rst_q", longint'(q_a), 0);
      chk("rst_ovf", longint'(ovf_a), 0);
      for (int k = 0; k <= 256; k++) begin
         tick(1, 1, 1, 0, 0, 0);
         chk("wrap_tc", longint'(s_tc[0]), longint'((k % 256) == 255));
         chk("wrap_q", longint'(q_a), longint'((k + 1) % 256));
         chk("wrap_ovf", longint'(ovf_a), longint'(((k + 1) % 256) == 0));
      end

      // Prescaler: 12 enabled clocks with one EN=0 gap at the fifth clock
      tick(0, 0, 1, 0, 0, 0);
      n = 0;
      for (int c = 0; c < 13; c++) begin
         tick(1, (c != 4), 1, 0, 0, 0);
         if (c != 4) n++;
         chk("pre_step", longint'(s_step[2]), longint'((c != 4) && (n % 4 == 0)));
      end
      chk("pre_q_end", longint'(q_c), 3);

      // BCD cascade: 100 clocks up
      tick(0, 0, 1, 0, 0, 0);
      ovf_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         tick(1, 1, 1, 0, 0, 0);
         v = (k + 1) % 100;
         chk("bcd_lo", longint'(q_k0), longint'(v % 10));
         chk("bcd_hi", longint'(q_k1), longint'(v / 10));
         if (ovf_k1) ovf_cnt++;
      end
      chk("bcd_ovf1_pulses", longint'(ovf_cnt), 1);

      // Random stimulus against the reference model
      for (int k = 0; k < 3000; k++) begin
         tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
              1'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
